// File: rtl/riscv_lsu.sv
// Load/store unit between the core's EX/MEM stage and the data BRAM.
// Relocates each request into RAM, issues byte-enabled word accesses and returns formatted load data or a fault.
module riscv_lsu #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 14,
    parameter int BASE_ADDR      = 16000,
    parameter int MEM_WORDS      = 4096,
    parameter int RAM_LATENCY    = 2
) (
    input  logic                      clk_100mhz,
    input  logic                      rst_n_in,
    input  logic                      req_valid_in,
    output logic                      req_ready_out,
    input  logic                      req_store_in,
    input  logic [2:0]                req_funct3_in,
    input  logic [ADDR_WIDTH-1:0]     req_addr_in,
    input  logic [31:0]               req_wdata_in,
    output logic                      rsp_valid_out,
    input  logic                      rsp_ready_in,
    output logic [31:0]               rsp_data_out,
    output logic                      rsp_fault_out,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_out,
    output logic                      mem_we_out,
    output logic [3:0]                mem_be_out,
    output logic [31:0]               mem_wdata_out,
    input  logic [31:0]               mem_rdata_in
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam int                    CNT_W      = $clog2(RAM_LATENCY + 1);
    localparam logic [CNT_W-1:0]      CNT_INIT   = CNT_W'(RAM_LATENCY);
    localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH + 1)'(4 * MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE_OFF   = ADDR_WIDTH'(BASE_ADDR);

    logic [1:0]                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      store_q, store_d;
    logic [2:0]                funct3_q, funct3_d;
    logic [1:0]                lane_q, lane_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [31:0]               rsp_data_q, rsp_data_d;
    logic                      rsp_fault_q, rsp_fault_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                      mem_we_q, mem_we_d;
    logic [3:0]                mem_be_q, mem_be_d;
    logic [31:0]               mem_wdata_q, mem_wdata_d;

    logic [ADDR_WIDTH-1:0]     off_s;
    logic                      illegal_s;
    logic                      misalign_s;
    logic                      range_s;
    logic                      fault_s;
    logic                      accept_s;
    logic                      unused_s;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   store_be = 4'b0001 << lane;
            2'b01:   store_be = 4'b0011 << lane;
            2'b10:   store_be = 4'b1111;
            default: store_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3[1:0])
            2'b00:   store_wdata = {4{wdata[7:0]}};
            2'b01:   store_wdata = {2{wdata[15:0]}};
            2'b10:   store_wdata = wdata;
            default: store_wdata = 32'd0;
        endcase
    endfunction

    // Halfwords are always lane-aligned here, so only lane[1] selects the half.
    function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = word[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  load_format = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_format = {{16{half_v[15]}}, half_v};
            3'b010:  load_format = word;
            3'b100:  load_format = {24'd0, byte_v};
            3'b101:  load_format = {16'd0, half_v};
            default: load_format = 32'd0;
        endcase
    endfunction

    assign req_ready_out = (state_q == ST_IDLE) && rst_n_in;
    assign accept_s      = req_valid_in && req_ready_out;
    assign unused_s      = ^{off_s[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2]};

    // Relocation and fault classification of the request on the input port.
    always_comb begin
        off_s = req_addr_in + BASE_OFF;
        case (req_funct3_in)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_s = 1'b0;
            default:                                illegal_s = 1'b1;
        endcase
        misalign_s = ((req_funct3_in[1:0] == 2'b01) && off_s[0]) ||
                     ((req_funct3_in[1:0] == 2'b10) && (off_s[1:0] != 2'b00));
        range_s    = {1'b0, req_addr_in} >= ADDR_LIMIT;
        fault_s    = illegal_s || (req_store_in && req_funct3_in[2]) || misalign_s || range_s;
    end

    // Next-state and next-output computation for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        store_d     = store_q;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    store_d  = req_store_in;
                    funct3_d = req_funct3_in;
                    lane_d   = off_s[1:0];
                    if (fault_s) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                        rsp_data_d  = 32'd0;
                    end else begin
                        state_d    = ST_ACCESS;
                        cnt_d      = CNT_INIT;
                        mem_addr_d = off_s[MEM_ADDR_WIDTH+1:2];
                        if (req_store_in) begin
                            mem_we_d    = 1'b1;
                            mem_be_d    = store_be(req_funct3_in, off_s[1:0]);
                            mem_wdata_d = store_wdata(req_funct3_in, req_wdata_in);
                        end else begin
                            mem_we_d = 1'b0;
                            mem_be_d = 4'b0000;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                mem_we_d = 1'b0;
                mem_be_d = 4'b0000;
                if (store_q) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = 1'b0;
                    rsp_data_d  = 32'd0;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = 1'b0;
                    rsp_data_d  = load_format(funct3_q, lane_q, mem_rdata_in);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_in) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_fault_d = 1'b0;
                    rsp_data_d  = 32'd0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, cleared by the synchronous active-low reset.
    always_ff @(posedge clk_100mhz) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            store_q     <= 1'b0;
            funct3_q    <= 3'd0;
            lane_q      <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_fault_q <= 1'b0;
            mem_addr_q  <= {MEM_ADDR_WIDTH{1'b0}};
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            store_q     <= store_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign rsp_valid_out = rsp_valid_q;
    assign rsp_data_out  = rsp_data_q;
    assign rsp_fault_out = rsp_fault_q;
    assign mem_addr_out  = mem_addr_q;
    assign mem_we_out    = mem_we_q;
    assign mem_be_out    = mem_be_q;
    assign mem_wdata_out = mem_wdata_q;

endmodule
